// File: rtl/uart_ibus_bridge.sv
// uart_ibus_bridge
//   UART (8N1) command decoder that masters the systolic4 ibus.
//   Host frames: 'W' AH AL DH DL -> one write strobe
//                'R' AH AL       -> one read strobe, reply DH DL on tx
//   Optional build macro BRIDGE_WR_ACK_EN: after each write, send 'K' (0x4B).
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active high
//   rx          UART receive line (asynchronous, idle high)
//   tx          UART transmit line (idle high)
//   ren         one-cycle read strobe;  ibus_radr valid with it
//   ibus_radr   read address
//   ibus_rdata  read data, valid RD_LAT cycles after ren
//   wen         one-cycle write strobe; ibus_wadr/ibus_wdata valid with it
//   ibus_wadr   write address
//   ibus_wdata  write data
//   busy        command FSM is not idle
//   frame_err   one-cycle pulse on a received byte with a low stop bit
//
// Command FSM states
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | waiting for an opcode byte
//   ADDR_H   | waiting for address high byte (timeout armed)
//   ADDR_L   | waiting for address low byte  (timeout armed)
//   DATA_H   | waiting for data high byte    (timeout armed)
//   DATA_L   | waiting for data low byte     (timeout armed)
//   WRITE    | wen for one cycle
//   READ     | ren for one cycle
//   RWAIT    | waiting RD_LAT cycles for read data
//   TX_H     | sending reply high byte
//   TX_L     | sending reply low byte
//   ACK      | sending write acknowledge (macro builds only)

module uart_ibus_bridge #(
    parameter int CLK_DIV  = 434,
    parameter int RD_LAT   = 1,
    parameter int TMO_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic        ren,
    output logic [15:0] ibus_radr,
    input  logic [15:0] ibus_rdata,
    output logic        wen,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata,
    output logic        busy,
    output logic        frame_err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L,
        S_WRITE, S_READ, S_RWAIT, S_TX_H, S_TX_L, S_ACK
    } state_t;

    // ---------------- receiver ----------------
    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_active;
    logic [3:0]    rx_bit;      // 0 = start, 1..8 = data, 9 = stop
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_shift;
    logic          rx_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_s3     <= 1'b1;
            rx_active <= 1'b0;
            rx_bit    <= 4'd0;
            rx_cnt    <= '0;
            rx_shift  <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_s3     <= rx_s2;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (!rx_active) begin
                if (rx_s3 && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_bit    <= 4'd0;
                    rx_cnt    <= HALF_LAST;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= BIT_LAST;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    // start bit gone high again at mid-bit: glitch, not a frame
                    if (rx_s2) rx_active <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    if (rx_s2) rx_valid  <= 1'b1;
                    else       frame_err <= 1'b1;
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                end
            end
        end
    end

    // ---------------- transmitter ----------------
    // tx is driven straight from the shift register LSB; ones are shifted in
    // so the line rests high once a byte has gone out.
    logic [9:0]    tx_shift;
    logic [3:0]    tx_left;
    logic [CW-1:0] tx_cnt;
    logic          tx_load;
    logic [7:0]    tx_byte;
    logic          tx_idle, tx_done;

    assign tx      = tx_shift[0];
    assign tx_idle = (tx_left == 4'd0);
    assign tx_done = (tx_left == 4'd1) && (tx_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '1;
            tx_left  <= 4'd0;
            tx_cnt   <= '0;
        end else if (tx_load) begin
            // a load in the last stop-bit cycle chains the next byte gap-free
            tx_shift <= {1'b1, tx_byte, 1'b0};
            tx_left  <= 4'd10;
            tx_cnt   <= BIT_LAST;
        end else if (!tx_idle) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end else begin
                tx_cnt   <= BIT_LAST;
                tx_left  <= tx_left - 4'd1;
                tx_shift <= {1'b1, tx_shift[9:1]};
            end
        end
    end

    // ---------------- command FSM ----------------
    state_t              state, state_n;
    logic                is_write;
    logic [15:0]         addr_q, data_q, hold_q;
    logic [2:0]          wait_cnt;
    logic [TMO_BITS-1:0] tmo_cnt;
    logic                tmo_hit;

    assign tmo_hit    = (tmo_cnt == '0);
    assign busy       = (state != S_IDLE);
    assign ibus_radr  = addr_q;
    assign ibus_wadr  = addr_q;
    assign ibus_wdata = data_q;

    always_comb begin
        state_n = state;
        tx_load = 1'b0;
        tx_byte = 8'h00;
        ren     = 1'b0;
        wen     = 1'b0;
        case (state)
            S_IDLE:   if (rx_valid && (rx_shift == 8'h57 || rx_shift == 8'h52)) state_n = S_ADDR_H;
            S_ADDR_H: if (rx_valid) state_n = S_ADDR_L; else if (tmo_hit) state_n = S_IDLE;
            S_ADDR_L: if (rx_valid) state_n = is_write ? S_DATA_H : S_READ;
                      else if (tmo_hit) state_n = S_IDLE;
            S_DATA_H: if (rx_valid) state_n = S_DATA_L; else if (tmo_hit) state_n = S_IDLE;
            S_DATA_L: if (rx_valid) state_n = S_WRITE; else if (tmo_hit) state_n = S_IDLE;
            S_WRITE: begin
                wen = 1'b1;
`ifdef BRIDGE_WR_ACK_EN
                state_n = S_ACK;
`else
                state_n = S_IDLE;
`endif
            end
            S_READ: begin
                ren     = 1'b1;
                state_n = S_RWAIT;
            end
            S_RWAIT:  if (wait_cnt == 3'd0) state_n = S_TX_H;
            S_TX_H: begin
                if (tx_done) begin
                    tx_load = 1'b1;
                    tx_byte = hold_q[7:0];
                    state_n = S_TX_L;
                end else if (tx_idle) begin
                    tx_load = 1'b1;
                    tx_byte = hold_q[15:8];
                end
            end
            S_TX_L:   if (tx_done) state_n = S_IDLE;
            S_ACK: begin
                if (tx_done) begin
                    state_n = S_IDLE;
                end else if (tx_idle) begin
                    tx_load = 1'b1;
                    tx_byte = 8'h4B;
                end
            end
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            is_write <= 1'b0;
            addr_q   <= 16'h0000;
            data_q   <= 16'h0000;
            hold_q   <= 16'h0000;
            wait_cnt <= 3'd0;
            tmo_cnt  <= '0;
        end else begin
            state <= state_n;
            if (rx_valid) begin
                case (state)
                    S_IDLE:   is_write      <= (rx_shift == 8'h57);
                    S_ADDR_H: addr_q[15:8]  <= rx_shift;
                    S_ADDR_L: addr_q[7:0]   <= rx_shift;
                    S_DATA_H: data_q[15:8]  <= rx_shift;
                    S_DATA_L: data_q[7:0]   <= rx_shift;
                    default: ;
                endcase
            end
            if (state == S_IDLE || rx_valid) tmo_cnt <= '1;
            else if (!tmo_hit)               tmo_cnt <= tmo_cnt - 1'b1;
            if (state == S_READ)
                wait_cnt <= 3'(RD_LAT - 1);
            else if (state == S_RWAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
            if (state == S_RWAIT && wait_cnt == 3'd0)
                hold_q <= ibus_rdata;
        end
    end

endmodule

// File: tb/tb_uart_ibus_bridge.sv
module tb_uart_ibus_bridge;

    localparam int CLK_DIV  = 16;
    localparam int RD_LAT   = 2;
    localparam int TMO_BITS = 8;
`ifdef BRIDGE_WR_ACK_EN
    localparam int ACK_TX = 1;
`else
    localparam int ACK_TX = 0;
`endif

    logic        clk, rst, rx, tx, ren, wen, busy, frame_err;
    logic [15:0] ibus_radr, ibus_rdata, ibus_wadr, ibus_wdata;

    uart_ibus_bridge #(.CLK_DIV(CLK_DIV), .RD_LAT(RD_LAT), .TMO_BITS(TMO_BITS)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx),
        .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
        .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata),
        .busy(busy), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    longint cyc = 0;

    // ---------------- ibus slave model (systolic4 stand-in) ----------------
    logic [15:0] resp_mem  [logic [15:0]];
    logic [15:0] model_mem [logic [15:0]];
    logic [15:0] pipe [RD_LAT];

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C};
    endfunction

    function automatic logic [15:0] resp_rd(input logic [15:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : dflt(a);
    endfunction

    // data is valid exactly RD_LAT cycles after ren, noise otherwise
    always @(posedge clk) begin
        pipe[0] <= ren ? resp_rd(ibus_radr) : 16'($urandom);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ibus_rdata = pipe[RD_LAT-1];

    // ---------------- monitors ----------------
    logic [31:0] wq[$];
    logic [15:0] rq[$];
    logic [7:0]  txq[$];
    longint      starts[$];
    int          fe_cnt, both_cnt, tx_bad_stop;
    logic [7:0]  mb;
    bit          mok;

    always @(negedge clk) begin
        cyc++;
        if (ren && wen) both_cnt++;
        if (wen) begin
            wq.push_back({ibus_wadr, ibus_wdata});
            resp_mem[ibus_wadr] = ibus_wdata;
        end
        if (ren) rq.push_back(ibus_radr);
        if (frame_err) fe_cnt++;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !rst) begin
                starts.push_back(cyc);
                repeat (CLK_DIV/2) @(negedge clk);
                mok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    mb[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                if (tx !== 1'b1) tx_bad_stop++;
                if (mok) txq.push_back(mb);
            end
        end
    end

    // ---------------- helpers ----------------
    typedef struct packed {
        int             nb;
        logic [4:0][7:0] b;
        bit             bad_stop;
        int             n_wen;
        logic [15:0]    wadr;
        logic [15:0]    wdata;
        int             n_ren;
        logic [15:0]    radr;
        int             n_tx;
        logic [7:0]     tx0;
        logic [7:0]     tx1;
        int             n_fe;
    } vec_t;

    function automatic vec_t mkv(input int nb, input logic [7:0] b0, b1, b2, b3, b4,
                                 input bit bad, input int nw, input logic [15:0] wa, wd,
                                 input int nr, input logic [15:0] ra,
                                 input int nt, input logic [7:0] t0, t1, input int nfe);
        vec_t v;
        v.nb = nb; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        v.bad_stop = bad; v.n_wen = nw; v.wadr = wa; v.wdata = wd;
        v.n_ren = nr; v.radr = ra; v.n_tx = nt; v.tx0 = t0; v.tx1 = t1; v.n_fe = nfe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (2*CLK_DIV) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 40*CLK_DIV) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic clear_mon();
        wq.delete(); rq.delete(); txq.delete(); starts.delete();
        fe_cnt = 0; both_cnt = 0; tx_bad_stop = 0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        clear_mon();
        for (int i = 0; i < v.nb; i++)
            send_byte(v.b[i], !(v.bad_stop && i == v.nb - 1));
        wait_idle(tag);
        repeat (12*CLK_DIV) @(negedge clk);
        chk({tag, "_nwen"}, wq.size(), v.n_wen);
        if (v.n_wen > 0 && wq.size() > 0) begin
            chk({tag, "_wadr"},  wq[0][31:16], v.wadr);
            chk({tag, "_wdata"}, wq[0][15:0],  v.wdata);
        end
        chk({tag, "_nren"}, rq.size(), v.n_ren);
        if (v.n_ren > 0 && rq.size() > 0) chk({tag, "_radr"}, rq[0], v.radr);
        chk({tag, "_ntx"}, txq.size(), v.n_tx);
        if (v.n_tx > 0 && txq.size() > 0) chk({tag, "_tx0"}, txq[0], v.tx0);
        if (v.n_tx > 1 && txq.size() > 1) chk({tag, "_tx1"}, txq[1], v.tx1);
        if (starts.size() == 2) chk({tag, "_txgap"}, 32'(starts[1] - starts[0]), 10*CLK_DIV);
        chk({tag, "_tx_stop"}, tx_bad_stop, 0);
        chk({tag, "_frame_err"}, fe_cnt, v.n_fe);
        chk({tag, "_ren_and_wen"}, both_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    vec_t tbl[5];
    logic [15:0] pool[4];

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        resp_mem[16'h0010]  = 16'hBEEF;  model_mem[16'h0010] = 16'hBEEF;
        resp_mem[16'h0030]  = 16'h0F0F;  model_mem[16'h0030] = 16'h0F0F;
        repeat (3) @(negedge clk);

        chk("rst_tx", tx, 1);
        chk("rst_ren", ren, 0);
        chk("rst_wen", wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_radr", ibus_radr, 0);
        chk("rst_wadr", ibus_wadr, 0);
        chk("rst_wdata", ibus_wdata, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        tbl[0] = mkv(5, 8'h57, 8'h12, 8'h34, 8'hAB, 8'hCD, 0, 1, 16'h1234, 16'hABCD,
                     0, 16'h0, ACK_TX, 8'h4B, 8'h00, 0);
        tbl[1] = mkv(3, 8'h52, 8'h00, 8'h10, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0,
                     1, 16'h0010, 2, 8'hBE, 8'hEF, 0);
        tbl[2] = mkv(1, 8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 16'h0, 16'h0,
                     0, 16'h0, 0, 8'h00, 8'h00, 1);
        tbl[3] = mkv(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0,
                     0, 16'h0, 0, 8'h00, 8'h00, 0);
        tbl[4] = mkv(3, 8'h52, 8'h12, 8'h34, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0,
                     1, 16'h1234, 2, 8'hAB, 8'hCD, 0);
        model_mem[16'h1234] = 16'hABCD;
        for (int i = 0; i < 5; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        // partial command abandoned by inter-byte timeout
        clear_mon();
        send_byte(8'h57, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (4*CLK_DIV) @(negedge clk);
        chk("tmo_pending_busy", busy, 1);
        repeat (2**TMO_BITS) @(negedge clk);
        chk("tmo_expired_busy", busy, 0);
        chk("tmo_no_wen", wq.size(), 0);
        chk("tmo_no_ren", rq.size(), 0);
        apply_vec(mkv(3, 8'h52, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0,
                      1, 16'h0001, 2, dflt(16'h0001) >> 8, dflt(16'h0001) & 16'hFF, 0),
                  "tmo_read");

        // reset in the middle of a reply byte (0x0F: data bit 4 is low)
        clear_mon();
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h30, 1'b1);
        begin
            int k = 0;
            while (tx !== 1'b0 && k < 30*CLK_DIV) begin
                @(negedge clk);
                k++;
            end
            chk("rstmid_tx_started", k < 30*CLK_DIV, 1);
        end
        repeat (5*CLK_DIV + CLK_DIV/2) @(negedge clk);
        chk("rstmid_tx_bit4", tx, 0);
        chk("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tx_after", tx, 1);
        chk("rstmid_busy_after", busy, 0);
        rst = 1'b0;
        repeat (12*CLK_DIV) @(negedge clk);
        chk("rstmid_nren", rq.size(), 1);
        chk("rstmid_nwen", wq.size(), 0);
        apply_vec(mkv(5, 8'h57, 8'h00, 8'h02, 8'h00, 8'h03, 0, 1, 16'h0002, 16'h0003,
                      0, 16'h0, ACK_TX, 8'h4B, 8'h00, 0), "rstmid_write");
        model_mem[16'h0002] = 16'h0003;

        // random commands against the memory model
        for (int i = 0; i < 4; i++) pool[i] = 16'($urandom);
        for (int n = 0; n < 20; n++) begin
            int op;
            logic [15:0] a, d, e;
            logic [7:0]  junk;
            op = $urandom_range(0, 2);
            a  = pool[$urandom_range(0, 3)];
            d  = 16'($urandom);
            if (op == 0) begin
                model_mem[a] = d;
                apply_vec(mkv(5, 8'h57, a[15:8], a[7:0], d[15:8], d[7:0], 0, 1, a, d,
                              0, 16'h0, ACK_TX, 8'h4B, 8'h00, 0), $sformatf("rnd%0d_w", n));
            end else if (op == 1) begin
                e = model_mem.exists(a) ? model_mem[a] : dflt(a);
                apply_vec(mkv(3, 8'h52, a[15:8], a[7:0], 8'h00, 8'h00, 0, 0, 16'h0, 16'h0,
                              1, a, 2, e[15:8], e[7:0], 0), $sformatf("rnd%0d_r", n));
            end else begin
                junk = 8'($urandom);
                if (junk == 8'h57 || junk == 8'h52) junk = 8'h33;
                apply_vec(mkv(1, junk, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0,
                              0, 16'h0, 0, 8'h00, 8'h00, 0), $sformatf("rnd%0d_j", n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
